// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver: FSM state encoding,
// legal oversampling ratios and parity-type codes.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } state_t;

    localparam logic [5:0] PRESC_8  = 6'd8;
    localparam logic [5:0] PRESC_16 = 6'd16;
    localparam logic [5:0] PRESC_32 = 6'd32;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Any ratio other than 8/16/32 falls back to 8.
    function automatic logic [5:0] legal_presc(input logic [5:0] p);
        case (p)
            PRESC_8, PRESC_16, PRESC_32: return p;
            default:                     return PRESC_8;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter and sample-point logic. With UART_RX_MAJORITY_SAMPLE_EN
// defined the bit is a 3-sample majority vote, otherwise one mid-bit sample.
module uart_rx_sampler (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_s,
    input  logic       start,
    input  logic       run,
    input  logic [5:0] presc,
    output logic       sampled_bit,
    output logic       sample_done,
    output logic       bit_end
);
    logic [5:0] edge_cnt;
    logic [5:0] half;

    assign half        = presc >> 1;
    assign sample_done = run && (edge_cnt == half + 6'd1);
    assign bit_end     = run && (edge_cnt == presc - 6'd1);

    // The start-detect cycle is edge 0, so the count resumes at 1.
    always_ff @(posedge clk) begin
        if (rst)
            edge_cnt <= 6'd0;
        else if (start)
            edge_cnt <= 6'd1;
        else if (run)
            edge_cnt <= bit_end ? 6'd0 : edge_cnt + 6'd1;
        else
            edge_cnt <= 6'd0;
    end

`ifdef UART_RX_MAJORITY_SAMPLE_EN
    logic s_early;
    logic s_mid;

    always_ff @(posedge clk) begin
        if (rst) begin
            s_early <= 1'b1;
            s_mid   <= 1'b1;
        end else begin
            if (run && edge_cnt == half - 6'd1)
                s_early <= rx_s;
            if (run && edge_cnt == half)
                s_mid <= rx_s;
        end
    end

    assign sampled_bit = (s_early & s_mid) | (s_early & rx_s) | (s_mid & rx_s);
`else
    logic s_mid;

    always_ff @(posedge clk) begin
        if (rst)
            s_mid <= 1'b1;
        else if (run && edge_cnt == half)
            s_mid <= rx_s;
    end

    assign sampled_bit = s_mid;
`endif

endmodule

// File: rtl/uart_rx.sv
// UART receiver top: input synchroniser, frame FSM and output registers.
// Build option: UART_RX_MAJORITY_SAMPLE_EN selects majority-vote bit sampling.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int Data_Width  = 8,
    parameter int Sync_Stages = 2
) (
    input  logic                  clk,
    input  logic                  RST,
    input  logic                  RX_In,
    input  logic [5:0]            Prescale,
    input  logic                  Par_En,
    input  logic                  Par_Type,
    output logic [Data_Width-1:0] P_Data,
    output logic                  Data_Valid,
    output logic                  Par_Err,
    output logic                  Stp_Err,
    output logic                  Busy,
    output logic [2:0]            state_dbg
);
    localparam int CW = (Data_Width > 1) ? $clog2(Data_Width) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(Data_Width - 1);

    logic [Sync_Stages-1:0] sync_q;
    logic                   rx_s;
    state_t                 state_q, next_state;
    logic [5:0]             presc_q;
    logic                   par_en_q, par_type_q, par_bad;
    logic [Data_Width-1:0]  word;
    logic [CW-1:0]          bit_cnt;
    logic                   start_det, run;
    logic                   sampled_bit, sample_done, bit_end;

    always_ff @(posedge clk) begin
        if (RST)
            sync_q <= '1;
        else
            sync_q <= {sync_q[Sync_Stages-2:0], RX_In};
    end

    assign rx_s      = sync_q[Sync_Stages-1];
    assign start_det = (state_q == IDLE) && !rx_s;
    assign run       = (state_q == START) || (state_q == DATA) ||
                       (state_q == PARITY) || (state_q == STOP);

    uart_rx_sampler u_sampler (
        .clk         (clk),
        .rst         (RST),
        .rx_s        (rx_s),
        .start       (start_det),
        .run         (run),
        .presc       (presc_q),
        .sampled_bit (sampled_bit),
        .sample_done (sample_done),
        .bit_end     (bit_end)
    );

    always_ff @(posedge clk) begin
        if (RST)
            state_q <= IDLE;
        else
            state_q <= next_state;
    end

    always_comb begin
        next_state = state_q;
        case (state_q)
            IDLE:      if (!rx_s) next_state = START;
            START: begin
                if (sample_done && sampled_bit)
                    next_state = IDLE;
                else if (bit_end)
                    next_state = DATA;
            end
            DATA:      if (bit_end && bit_cnt == LAST_BIT)
                           next_state = par_en_q ? PARITY : STOP;
            PARITY:    if (bit_end) next_state = STOP;
            STOP:      if (sample_done) next_state = sampled_bit ? IDLE : WAIT_IDLE;
            WAIT_IDLE: if (rx_s) next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    // Output contract: Data_Valid, Par_Err and Stp_Err are single-cycle strobes
    // with no back-pressure; P_Data is only meaningful from a Data_Valid onward.
    always_ff @(posedge clk) begin
        if (RST) begin
            presc_q    <= PRESC_8;
            par_en_q   <= 1'b0;
            par_type_q <= PAR_EVEN;
            par_bad    <= 1'b0;
            word       <= '0;
            bit_cnt    <= '0;
            P_Data     <= '0;
            Data_Valid <= 1'b0;
            Par_Err    <= 1'b0;
            Stp_Err    <= 1'b0;
        end else begin
            Data_Valid <= 1'b0;
            Par_Err    <= 1'b0;
            Stp_Err    <= 1'b0;
            if (start_det) begin
                presc_q    <= legal_presc(Prescale);
                par_en_q   <= Par_En;
                par_type_q <= Par_Type;
                par_bad    <= 1'b0;
                bit_cnt    <= '0;
            end
            if (state_q == DATA) begin
                if (sample_done)
                    word[bit_cnt] <= sampled_bit;
                if (bit_end)
                    bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
            end
            if (state_q == PARITY && sample_done)
                par_bad <= sampled_bit != ((^word) ^ par_type_q);
            if (state_q == STOP && sample_done) begin
                if (sampled_bit) begin
                    if (par_bad) begin
                        Par_Err <= 1'b1;
                    end else begin
                        P_Data     <= word;
                        Data_Valid <= 1'b1;
                    end
                end else begin
                    Stp_Err <= 1'b1;
                    Par_Err <= par_bad;
                end
            end
        end
    end

    assign Busy      = (state_q != IDLE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames
// checked against a frame-level expected queue.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       RST = 1'b1;
    logic       RX_In = 1'b1;
    logic [5:0] Prescale = 6'd8;
    logic       Par_En = 1'b0;
    logic       Par_Type = 1'b0;
    logic [7:0] P_Data;
    logic       Data_Valid, Par_Err, Stp_Err, Busy;
    logic [2:0] state_dbg;

    int n_assert = 0;
    int n_fail   = 0;
    int dv_cnt = 0, pe_cnt = 0, se_cnt = 0;
    logic prev_dv = 1'b0, prev_pe = 1'b0, prev_se = 1'b0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    uart_rx dut (
        .clk        (clk),
        .RST        (RST),
        .RX_In      (RX_In),
        .Prescale   (Prescale),
        .Par_En     (Par_En),
        .Par_Type   (Par_Type),
        .P_Data     (P_Data),
        .Data_Valid (Data_Valid),
        .Par_Err    (Par_Err),
        .Stp_Err    (Stp_Err),
        .Busy       (Busy),
        .state_dbg  (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // output monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (Data_Valid) begin
            got_q.push_back(P_Data);
            dv_cnt++;
            n_assert++;
            if (prev_dv) begin
                n_fail++;
                $display("FAIL dv_width: Data_Valid high 2 cycles, got 1 required 0");
            end
        end
        if (Par_Err) begin
            pe_cnt++;
            n_assert++;
            if (prev_pe) begin
                n_fail++;
                $display("FAIL pe_width: Par_Err high 2 cycles, got 1 required 0");
            end
        end
        if (Stp_Err) begin
            se_cnt++;
            n_assert++;
            if (prev_se) begin
                n_fail++;
                $display("FAIL se_width: Stp_Err high 2 cycles, got 1 required 0");
            end
        end
        prev_dv = Data_Valid;
        prev_pe = Par_Err;
        prev_se = Stp_Err;
    end

    // driver tasks
    task automatic idle(input int n);
        RX_In = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int p, input logic [5:0] presc_val,
                              input logic pen, input logic ptype, input logic flip_par,
                              input logic stop_val, input logic scramble);
        logic par;
        par = (^d) ^ ptype ^ flip_par;
        Prescale = presc_val;
        Par_En   = pen;
        Par_Type = ptype;
        RX_In    = 1'b0;
        repeat (p) @(negedge clk);
        if (scramble) begin
            Prescale = 6'($urandom_range(0, 63));
            Par_En   = 1'($urandom_range(0, 1));
            Par_Type = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < 8; i++) begin
            RX_In = d[i];
            repeat (p) @(negedge clk);
        end
        if (pen) begin
            RX_In = par;
            repeat (p) @(negedge clk);
        end
        RX_In = stop_val;
        repeat (p) @(negedge clk);
    endtask

    // scenarios
    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(negedge clk);
        RST = 1'b0;
        @(negedge clk);
        n_assert += 6;
        if (P_Data !== 8'h00) begin n_fail++; $display("FAIL rst_pdata: got %h required 00", P_Data); end
        if (Data_Valid !== 1'b0) begin n_fail++; $display("FAIL rst_dv: got %b required 0", Data_Valid); end
        if (Par_Err !== 1'b0) begin n_fail++; $display("FAIL rst_pe: got %b required 0", Par_Err); end
        if (Stp_Err !== 1'b0) begin n_fail++; $display("FAIL rst_se: got %b required 0", Stp_Err); end
        if (Busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b required 0", Busy); end
        if (state_dbg !== 3'd0) begin n_fail++; $display("FAIL rst_state: got %0d required 0", state_dbg); end
    endtask

    task automatic test_basic();
        int dv0, pe0, se0;
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        fork
            send_frame(8'hA5, 8, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            begin
                repeat (40) @(negedge clk);
                n_assert++;
                if (Busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_mid: got %b required 1", Busy); end
            end
        join
        idle(8);
        n_assert += 5;
        if (dv_cnt - dv0 != 1) begin n_fail++; $display("FAIL basic_dv_count: got %0d required 1", dv_cnt - dv0); end
        if (P_Data !== 8'hA5) begin n_fail++; $display("FAIL basic_pdata: got %h required a5", P_Data); end
        if (pe_cnt != pe0) begin n_fail++; $display("FAIL basic_pe: got %0d required 0", pe_cnt - pe0); end
        if (se_cnt != se0) begin n_fail++; $display("FAIL basic_se: got %0d required 0", se_cnt - se0); end
        if (Busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end: got %b required 0", Busy); end
    endtask

    task automatic test_parity();
        int dv0, pe0;
        dv0 = dv_cnt; pe0 = pe_cnt;
        send_frame(8'hAA, 8, 6'd8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(8);
        n_assert += 2;
        if (dv_cnt - dv0 != 1) begin n_fail++; $display("FAIL par_good_dv: got %0d required 1", dv_cnt - dv0); end
        if (P_Data !== 8'hAA) begin n_fail++; $display("FAIL par_good_pdata: got %h required aa", P_Data); end
        dv0 = dv_cnt;
        send_frame(8'hAA, 8, 6'd8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(8);
        n_assert += 3;
        if (pe_cnt - pe0 != 1) begin n_fail++; $display("FAIL par_bad_pe: got %0d required 1", pe_cnt - pe0); end
        if (dv_cnt != dv0) begin n_fail++; $display("FAIL par_bad_dv: got %0d required 0", dv_cnt - dv0); end
        if (P_Data !== 8'hAA) begin n_fail++; $display("FAIL par_bad_pdata: got %h required aa", P_Data); end
    endtask

    task automatic test_glitch();
        int dv0, pe0, se0;
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        Prescale = 6'd16;
        Par_En   = 1'b0;
        RX_In    = 1'b0;
        repeat (2) @(negedge clk);
        RX_In = 1'b1;
        repeat (2) @(negedge clk);
        n_assert++;
        if (Busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_start: got %b required 1", Busy); end
        idle(20);
        n_assert += 2;
        if (Busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_end: got %b required 0", Busy); end
        if (dv_cnt != dv0 || pe_cnt != pe0 || se_cnt != se0) begin
            n_fail++;
            $display("FAIL glitch_flags: got %0d pulses required 0", (dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0));
        end
        send_frame(8'h3C, 16, 6'd16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(8);
        n_assert++;
        if (P_Data !== 8'h3C || dv_cnt - dv0 != 1) begin
            n_fail++;
            $display("FAIL glitch_next_frame: got %h (%0d pulses) required 3c (1 pulse)", P_Data, dv_cnt - dv0);
        end
    endtask

    task automatic test_break();
        int dv0, se0;
        dv0 = dv_cnt; se0 = se_cnt;
        send_frame(8'h81, 8, 6'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        n_assert += 3;
        if (se_cnt - se0 != 1) begin n_fail++; $display("FAIL break_se: got %0d required 1", se_cnt - se0); end
        if (Busy !== 1'b1) begin n_fail++; $display("FAIL break_busy_low: got %b required 1", Busy); end
        if (dv_cnt != dv0) begin n_fail++; $display("FAIL break_dv: got %0d required 0", dv_cnt - dv0); end
        idle(10);
        n_assert += 2;
        if (Busy !== 1'b0) begin n_fail++; $display("FAIL break_busy_release: got %b required 0", Busy); end
        if (se_cnt - se0 != 1 || dv_cnt != dv0) begin
            n_fail++;
            $display("FAIL break_extra_frames: got %0d stp %0d dv required 1 stp 0 dv", se_cnt - se0, dv_cnt - dv0);
        end
    endtask

    task automatic test_back_to_back();
        got_q.delete();
        send_frame(8'h55, 16, 6'd16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(8'h0F, 16, 6'd16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(16);
        n_assert++;
        if (got_q.size() != 2) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d required 2", got_q.size());
        end else begin
            n_assert += 2;
            if (got_q[0] !== 8'h55) begin n_fail++; $display("FAIL b2b_first: got %h required 55", got_q[0]); end
            if (got_q[1] !== 8'h0F) begin n_fail++; $display("FAIL b2b_second: got %h required 0f", got_q[1]); end
        end
    endtask

    task automatic test_reset_midframe();
        int dv0, pe0, se0;
        logic [7:0] d;
        d = 8'h00;
        Prescale = 6'd8;
        Par_En   = 1'b0;
        RX_In    = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            RX_In = d[i];
            repeat (8) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        RST   = 1'b1;
        RX_In = 1'b1;
        @(negedge clk);
        RST = 1'b0;
        n_assert += 5;
        if (P_Data !== 8'h00) begin n_fail++; $display("FAIL midrst_pdata: got %h required 00", P_Data); end
        if (Busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b required 0", Busy); end
        if (Data_Valid !== 1'b0) begin n_fail++; $display("FAIL midrst_dv: got %b required 0", Data_Valid); end
        if (Par_Err !== 1'b0 || Stp_Err !== 1'b0) begin n_fail++; $display("FAIL midrst_err: got %b%b required 00", Par_Err, Stp_Err); end
        if (state_dbg !== 3'd0) begin n_fail++; $display("FAIL midrst_state: got %0d required 0", state_dbg); end
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        idle(100);
        n_assert++;
        if (dv_cnt != dv0 || pe_cnt != pe0 || se_cnt != se0) begin
            n_fail++;
            $display("FAIL midrst_no_pulse: got %0d pulses required 0", (dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0));
        end
        send_frame(8'hC3, 8, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(8);
        n_assert++;
        if (P_Data !== 8'hC3 || dv_cnt - dv0 != 1) begin
            n_fail++;
            $display("FAIL midrst_next_frame: got %h (%0d pulses) required c3 (1 pulse)", P_Data, dv_cnt - dv0);
        end
    endtask

    task automatic test_random();
        int pe0, se0, exp_pe, p, sel;
        logic [7:0] d;
        logic [5:0] pv;
        logic pen, ptype, flip;
        got_q.delete();
        exp_q.delete();
        pe0 = pe_cnt; se0 = se_cnt; exp_pe = 0;
        for (int n = 0; n < 24; n++) begin
            d     = 8'($urandom);
            pen   = 1'($urandom_range(0, 1));
            ptype = 1'($urandom_range(0, 1));
            flip  = pen && ($urandom_range(0, 4) == 0);
            sel   = $urandom_range(0, 3);
            case (sel)
                0: begin p = 8;  pv = 6'd8;  end
                1: begin p = 16; pv = 6'd16; end
                2: begin p = 32; pv = 6'd32; end
                default: begin
                    p  = 8;
                    pv = 6'($urandom_range(0, 63));
                    while (pv == 6'd8 || pv == 6'd16 || pv == 6'd32)
                        pv = 6'($urandom_range(0, 63));
                end
            endcase
            if (flip) exp_pe++;
            else      exp_q.push_back(d);
            send_frame(d, p, pv, pen, ptype, flip, 1'b1, 1'b1);
            idle($urandom_range(0, 3));
        end
        idle(40);
        n_assert += 3;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rand_count: got %0d words required %0d", got_q.size(), exp_q.size());
        end
        if (pe_cnt - pe0 != exp_pe) begin n_fail++; $display("FAIL rand_pe: got %0d required %0d", pe_cnt - pe0, exp_pe); end
        if (se_cnt != se0) begin n_fail++; $display("FAIL rand_se: got %0d required 0", se_cnt - se0); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_assert++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rand_word_%0d: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_glitch();
        test_break();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
